wb_dual_writer: RTL and testbench
=================================

Name: wb_dual_writer

Overview:
- Writeback side of the dual-issue register file: collects results from the two issue lanes, buffers them in order and drives the two register-file write ports (write1/rd1/write1_data, write2/rd2/write2_data).
- Up to two results enqueued and two writes retired per cycle; program order preserved.
- Exports a pending-write mask for issue-stage hazard checks.

Parameters:
- DEPTH, 8, buffer entries; power of two, >= 4
- XLEN, 32, data width
- REG_AW, 5, register address width (32 architectural registers)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in1_valid  in  1  lane-1 (older) result valid
- in1_rd  in  REG_AW  lane-1 destination register
- in1_data  in  XLEN  lane-1 result
- in2_valid  in  1  lane-2 (younger) result valid
- in2_rd  in  REG_AW  lane-2 destination register
- in2_data  in  XLEN  lane-2 result
- in_ready  out  1  buffer can take two results this cycle
- write1  out  1  register-file port-1 write enable
- rd1  out  REG_AW  port-1 address
- write1_data  out  XLEN  port-1 data
- write2  out  1  register-file port-2 write enable
- rd2  out  REG_AW  port-2 address
- write2_data  out  XLEN  port-2 data
- busy_mask  out  2**REG_AW  bit r set while a buffered write targets register r
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: circular buffer of DEPTH entries {rd, data}. head/tail pointers wrap modulo DEPTH. Count register tracks occupancy.
- Reset (rst_n low, async): head=tail=count=0. All outputs derive from this state, so write1=write2=0, rd1=rd2=0, write1_data=write2_data=0, busy_mask=0, in_ready=1.
- in_ready = (count <= DEPTH-2). It is combinational from registered count and independent of in*_valid.
- Accept rule: lane k is accepted when ink_valid && in_ready.
  - A lane with rd==0 is accepted but discarded (not stored).
  - When both lanes are stored, lane 1 is written at tail and lane 2 at tail+1.
  - When only one lane is stored, it goes at tail.
  - tail advances by the number of stored entries (0/1/2).
- Drain (combinational from registered state):
  - write1 = (count>=1), driving rd1/write1_data from head.
  - write2 = (count>=2) && (entry[head+1].rd != entry[head].rd), driving rd2/write2_data from head+1.
  - When write1=0, rd1/write1_data are 0; same rule for port 2.
  - At each rising edge, head advances by write1+write2 (the register file samples on that same edge).
- Same-rd pair: only the older entry retires that cycle; the younger retires next cycle on port 1. No WAW reordering.
- Latency: a result accepted at edge k is written into the register file at edge k+1 (when at head), i.e. one cycle minimum.
- Simultaneous push/pop: count_next = count + pushed − popped. Entries pushed at edge k are not popped at edge k.
- Full: count==DEPTH−1 or DEPTH deasserts in_ready; no overflow is possible. Empty: both writes 0.
- busy_mask: OR over valid entries of onehot(rd). Bit 0 is always 0. It covers entries being retired this cycle; it clears the cycle after retirement.
- No stall input: the register file always accepts, so drain never blocks.

Decomposition:
- Shared package wb_pkg holds the entry typedef wb_entry_t {rd, data} and the REG_AW/XLEN constants, shared with the register file.
- One sub-module: wb_onehot_mask (rd → 2**REG_AW one-hot, bit 0 forced 0), instantiated per entry and OR-reduced.
- Pointer/count logic stays in the top.

Test Plan:
- Reset: hold rst_n=0 mid-stream with 3 entries buffered → immediately write1=write2=0, count=0, busy_mask=0, in_ready=1.
- Dual push: in1={rd=5,0xAAAA_0001}, in2={rd=6,0xBBBB_0002} for one cycle → next cycle write1 rd1=5 and write2 rd2=6 with those data; busy_mask bits 5,6 set for exactly one cycle; count 2→0.
- x0 drop: in1 rd=0, in2 rd=7 data 0x77 → only port 1 writes rd=7; count peaks at 1; write2=0.
- Same-rd pair: in1={rd=9,0x1}, in2={rd=9,0x2} → cycle N write1 rd=9 data 0x1 with write2=0; cycle N+1 write1 rd=9 data 0x2.
- Fill/backpressure: repeat same-rd pairs rd=3 every cycle (drain 1/cycle) → count climbs to DEPTH−1 (7), in_ready drops, no lost or reordered entries; the data sequence out equals the sequence in.
- Wrap-around: stream 20 distinct {rd=i%31+1, data=i} pairs → all 20 written in order across the pointer wrap; count returns to 0.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_pkg : shared writeback entry type and register-file widths        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_onehot_mask.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_onehot_mask : register index to one-hot mask, x0 never marked     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_onehot_mask #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0]     rd,
  output logic [2**REG_AW-1:0]  mask
);

  always_comb begin
    mask = '0;
    if (rd != '0) mask[rd] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/wb_dual_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_dual_writer : in-order dual-lane writeback buffer, 2 RF ports     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_dual_writer #(
  parameter int DEPTH  = 8,
  parameter int XLEN   = wb_pkg::XLEN,
  parameter int REG_AW = wb_pkg::REG_AW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in1_valid,
  input  logic [REG_AW-1:0]         in1_rd,
  input  logic [XLEN-1:0]           in1_data,
  input  logic                      in2_valid,
  input  logic [REG_AW-1:0]         in2_rd,
  input  logic [XLEN-1:0]           in2_data,
  output logic                      in_ready,
  output logic                      write1,
  output logic [REG_AW-1:0]         rd1,
  output logic [XLEN-1:0]           write1_data,
  output logic                      write2,
  output logic [REG_AW-1:0]         rd2,
  output logic [XLEN-1:0]           write2_data,
  output logic [2**REG_AW-1:0]      busy_mask,
  output logic [$clog2(DEPTH):0]    count
);
  import wb_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t          mem [DEPTH];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic               store1;
  logic               store2;
  logic [PW-1:0]      slot2;
  logic [1:0]         push_n;
  logic [1:0]         pop_n;
  wb_entry_t          e0;
  wb_entry_t          e1;

  always_comb begin
    in_ready    = (count <= CW'(DEPTH - 2));
    store1      = in1_valid && in_ready && (in1_rd != '0);
    store2      = in2_valid && in_ready && (in2_rd != '0);
    slot2       = store1 ? tail + PW'(1) : tail;
    push_n      = {1'b0, store1} + {1'b0, store2};
    e0          = mem[head];
    e1          = mem[head + PW'(1)];
    write1      = (count != '0);
    // A same-rd pair retires one per cycle so the younger value lands last.
    write2      = (count >= CW'(2)) && (e1.rd != e0.rd);
    rd1         = write1 ? e0.rd   : '0;
    write1_data = write1 ? e0.data : '0;
    rd2         = write2 ? e1.rd   : '0;
    write2_data = write2 ? e1.data : '0;
    pop_n       = {1'b0, write1} + {1'b0, write2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (store1) mem[tail]  <= '{rd: in1_rd, data: in1_data};
    if (store2) mem[slot2] <= '{rd: in2_rd, data: in2_data};
  end

  logic [2**REG_AW-1:0] entry_mask [DEPTH];
  logic [DEPTH-1:0]     entry_live;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PW-1:0] offset;
    assign offset        = PW'(i) - head;
    assign entry_live[i] = ({1'b0, offset} < count);
    wb_onehot_mask #(.REG_AW(REG_AW)) u_mask (
      .rd   (mem[i].rd),
      .mask (entry_mask[i])
    );
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_live[i]) busy_mask = busy_mask | entry_mask[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_dual_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_dual_writer : directed vectors plus in-order reference queue   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wb_dual_writer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in1_valid, in2_valid;
  logic [4:0]  in1_rd, in2_rd;
  logic [31:0] in1_data, in2_data;
  logic        in_ready, write1, write2;
  logic [4:0]  rd1, rd2;
  logic [31:0] write1_data, write2_data;
  logic [31:0] busy_mask;
  logic [3:0]  count;

  wb_dual_writer #(.DEPTH(DEPTH), .XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in1_valid(in1_valid), .in1_rd(in1_rd), .in1_data(in1_data),
    .in2_valid(in2_valid), .in2_rd(in2_rd), .in2_data(in2_data),
    .in_ready(in_ready),
    .write1(write1), .rd1(rd1), .write1_data(write1_data),
    .write2(write2), .rd2(rd2), .write2_data(write2_data),
    .busy_mask(busy_mask), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   dut_writes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: compare outputs with the reference queue,
  // drive the next inputs, advance the queue, and move to the next falling edge.
  task automatic cycle(input bit v1, input logic [4:0] r1, input logic [31:0] d1,
                       input bit v2, input logic [4:0] r2, input logic [31:0] d2,
                       output bit acc);
    int          n;
    bit          ew1, ew2;
    logic [31:0] em;
    n   = q.size();
    ew1 = (n >= 1);
    ew2 = (n >= 2) && (q[1].rd != q[0].rd);
    em  = '0;
    foreach (q[j]) em[q[j].rd] = 1'b1;
    check("in_ready", in_ready, (n <= DEPTH - 2));
    check("count", count, n);
    check("write1", write1, ew1);
    check("rd1", rd1, ew1 ? q[0].rd : 5'd0);
    check("write1_data", write1_data, ew1 ? q[0].data : 32'd0);
    check("write2", write2, ew2);
    check("rd2", rd2, ew2 ? q[1].rd : 5'd0);
    check("write2_data", write2_data, ew2 ? q[1].data : 32'd0);
    check("busy_mask", busy_mask, em);
    dut_writes += int'(write1) + int'(write2);
    acc = (n <= DEPTH - 2);
    in1_valid = v1; in1_rd = r1; in1_data = d1;
    in2_valid = v2; in2_rd = r2; in2_data = d2;
    if (ew1) void'(q.pop_front());
    if (ew2) void'(q.pop_front());
    if (acc && v1 && r1 != 0) q.push_back('{rd: r1, data: d1});
    if (acc && v2 && r2 != 0) q.push_back('{rd: r2, data: d2});
    @(negedge clk);
  endtask

  task automatic idle();
    bit a;
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k, maxc;
    bit saw_block;
    rst_n = 1'b0;
    in1_valid = 0; in1_rd = 0; in1_data = 0;
    in2_valid = 0; in2_rd = 0; in2_data = 0;
    repeat (2) @(negedge clk);
    check("rst_write1", write1, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // dual push
    cycle(1, 5'd5, 32'hAAAA_0001, 1, 5'd6, 32'hBBBB_0002, acc);
    check("dp_rd1", rd1, 5);
    check("dp_data1", write1_data, 32'hAAAA_0001);
    check("dp_rd2", rd2, 6);
    check("dp_data2", write2_data, 32'hBBBB_0002);
    check("dp_busy", busy_mask, 32'h0000_0060);
    check("dp_count", count, 2);
    idle();
    check("dp_busy_clr", busy_mask, 0);
    check("dp_count_end", count, 0);

    // x0 drop
    cycle(1, 5'd0, 32'h55, 1, 5'd7, 32'h77, acc);
    check("x0_count", count, 1);
    check("x0_rd1", rd1, 7);
    check("x0_data1", write1_data, 32'h77);
    check("x0_write2", write2, 0);
    idle();

    // same-rd pair
    cycle(1, 5'd9, 32'h1, 1, 5'd9, 32'h2, acc);
    check("srd_w1", write1, 1);
    check("srd_data_a", write1_data, 32'h1);
    check("srd_w2", write2, 0);
    idle();
    check("srd_rd_b", rd1, 9);
    check("srd_data_b", write1_data, 32'h2);
    idle();
    check("srd_count_end", count, 0);

    // asynchronous reset with entries buffered
    cycle(1, 5'd10, 32'hA0, 1, 5'd10, 32'hA1, acc);
    cycle(1, 5'd10, 32'hA2, 1, 5'd10, 32'hA3, acc);
    in1_valid = 0; in2_valid = 0;
    check("prerst_count", count, 3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_write1", write1, 0);
    check("arst_write2", write2, 0);
    check("arst_count", count, 0);
    check("arst_busy", busy_mask, 0);
    check("arst_in_ready", in_ready, 1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // fill and backpressure with same-rd pairs
    k = 0; maxc = 0; saw_block = 0;
    for (int it = 0; it < 60 && k < 24; it++) begin
      cycle(1, 5'd3, 32'h300 + k, 1, 5'd3, 32'h301 + k, acc);
      if (acc) k += 2;
      if (int'(count) > maxc) maxc = int'(count);
      if (!in_ready) saw_block = 1;
    end
    for (int t = 0; t < 40 && q.size() != 0; t++) idle();
    check("fill_peak", maxc, DEPTH - 1);
    check("fill_blocked", saw_block, 1);
    check("fill_count_end", count, 0);

    // wrap-around stream of 20 distinct entries
    dut_writes = 0;
    k = 0;
    for (int it = 0; it < 40 && k < 20; it++) begin
      cycle(1, 5'((k % 31) + 1), 32'(k), 1, 5'(((k + 1) % 31) + 1), 32'(k + 1), acc);
      if (acc) k += 2;
    end
    for (int t = 0; t < 40 && q.size() != 0; t++) idle();
    check("wrap_writes", dut_writes, 20);
    check("wrap_count_end", count, 0);
    check("wrap_in_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
